// File: rtl/pipe_buffer.sv
// pipe_buffer: one pipeline stage between two datapath stages, carrying one
// WIDTH-bit payload per transfer under a valid/ready handshake.
//
// Parameters
//   WIDTH : payload width in bits (>= 1)
//   SKID  : 0 = single-entry stall register (in_ready combinational from
//           out_ready); 1 = two-entry skid buffer (in_ready from flops only)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream offers in_data
//   in_ready   buffer accepts this cycle
//   in_data    payload from the upstream stage
//   flush      synchronous squash of every held entry
//   out_valid  out_data holds a live entry
//   out_ready  downstream takes the entry this cycle
//   out_data   oldest held payload
//   xfer_cnt   count of output transfers, wraps at 2^16
//   stall_cnt  count of backpressure cycles, saturates at 0xFFFF
module pipe_buffer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      xfer_cnt,
  output logic [15:0]      stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_next;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_next;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  // Skid mode decodes in_ready purely from the state register; the stall
  // register variant lets a downstream stall reach upstream in the same cycle.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state != TWO);
    end else begin : g_stall_ready
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Next state and data-register updates. Flush overrides everything and
  // leaves the data registers untouched; a same-cycle in_fire is dropped.
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_next = TWO;
            skid_next  = in_data;
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            state_next = ONE;
            main_next  = skid_q;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

  // Counters are reset-only; flush does not touch them. An out_fire in the
  // flush cycle is still a completed transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_fire) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

endmodule
